// File: rtl/key_event_ctrl_if.sv
// Key-event controller interface: scanner-side inputs plus event-queue handshake and status.
// The controller binds to the slave modport; the scanner/consumer side uses master.
interface key_event_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    code;
  logic          valid;
  logic [3:0]    ev_code;
  logic          ev_valid;
  logic          ev_ready;
  logic          pressed;
  logic          overflow;
  logic          clr_ovf;
  logic [CW-1:0] count;

  modport master (
    output code, valid, ev_ready, clr_ovf,
    input  ev_code, ev_valid, pressed, overflow, count
  );

  modport slave (
    input  code, valid, ev_ready, clr_ovf,
    output ev_code, ev_valid, pressed, overflow, count
  );
endinterface

// File: rtl/key_event_ctrl.sv
// Key-event controller: debounces scanner output into one event per key press and
// queues accepted codes in a first-word-fall-through FIFO with a valid/ready drain.
//
// state | meaning
// IDLE  | no key; waiting for a scanner valid
// QUAL  | candidate code seen, counting matching valid samples
// HELD  | press accepted and queued; key still down
// REL   | valid dropped, counting low samples before declaring release
module key_event_ctrl #(
  parameter int DEB_CYCLES = 3,
  parameter int REL_CYCLES = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  key_event_ctrl_if.slave kif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] REL_LAST = 4'(REL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_HELD, S_REL} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          push_req;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full, empty, do_push, do_pop, drop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kif.valid) begin
          cand_d  = kif.code;
          cnt_d   = 4'd1;
          state_d = S_QUAL;
        end
      end
      S_QUAL: begin
        if (!kif.valid) begin
          state_d = S_IDLE;
        end else if (kif.code != cand_q) begin
          cand_d = kif.code;
          cnt_d  = 4'd1;
        end else if (cnt_q == DEB_LAST) begin
          push_req = 1'b1;
          state_d  = S_HELD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HELD: begin
        if (!kif.valid) begin
          cnt_d   = 4'd1;
          state_d = S_REL;
        end
      end
      S_REL: begin
        // A valid during release counting is bounce: return to HELD without a new event.
        if (kif.valid) begin
          state_d = S_HELD;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = !empty && kif.ev_ready;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)             ovf_q <= 1'b1;
      else if (kif.clr_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= cand_q;
  end

  assign kif.ev_valid = !empty;
  assign kif.ev_code  = empty ? 4'd0 : mem_q[rd_ptr_q];
  assign kif.pressed  = (state_q == S_HELD) || (state_q == S_REL);
  assign kif.overflow = ovf_q;
  assign kif.count    = count_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: table-driven single-key vectors followed by
// hand-written overflow, full push+pop and asynchronous-reset sequences.
module tb_key_event_ctrl;
  logic clock;
  logic reset;
  int   n_pass = 0;
  int   n_tot  = 0;

  key_event_ctrl_if #(.FIFO_DEPTH(4)) kif ();

  key_event_ctrl #(
    .DEB_CYCLES(3),
    .REL_CYCLES(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kif  (kif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       rdy;
    logic       exp_ev;
    logic [3:0] exp_code;
    logic [2:0] exp_cnt;
    logic       exp_pr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [3:0] c, input logic rdy,
                              input logic ev, input logic [3:0] ec, input logic [2:0] cnt,
                              input logic pr);
    vec_t t;
    t.v = v; t.c = c; t.rdy = rdy;
    t.exp_ev = ev; t.exp_code = ec; t.exp_cnt = cnt; t.exp_pr = pr;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    kif.valid = 1'b1;
    kif.code  = c;
    repeat (3) step();
    kif.valid = 1'b0;
    kif.code  = 4'd0;
    repeat (3) step();
  endtask

  initial begin
    logic [3:0] exp_q [4];

    reset       = 1'b0;
    kif.valid   = 1'b0;
    kif.code    = 4'd0;
    kif.ev_ready = 1'b0;
    kif.clr_ovf = 1'b0;
    #12;
    chk("rst ev_valid", 8'(kif.ev_valid), 8'd0);
    chk("rst ev_code",  8'(kif.ev_code),  8'd0);
    chk("rst count",    8'(kif.count),    8'd0);
    chk("rst pressed",  8'(kif.pressed),  8'd0);
    chk("rst overflow", 8'(kif.overflow), 8'd0);
    reset = 1'b1;

    // clean press, code 5 held 10 samples
    add(1,5,0, 0,0,0,0);
    add(1,5,0, 0,0,0,0);
    add(1,5,0, 1,5,1,1);
    for (int k = 0; k < 7; k++) add(1,5,0, 1,5,1,1);
    add(0,0,0, 1,5,1,1);
    add(0,0,0, 1,5,1,1);
    add(0,0,0, 1,5,1,0);
    add(0,0,0, 1,5,1,0);
    add(0,0,1, 0,0,0,0);
    add(0,0,1, 0,0,0,0);
    // short glitch
    add(1,2,0, 0,0,0,0);
    add(1,2,0, 0,0,0,0);
    for (int k = 0; k < 4; k++) add(0,0,0, 0,0,0,0);
    // code change 3 -> 9
    add(1,3,0, 0,0,0,0);
    add(1,3,0, 0,0,0,0);
    add(1,9,0, 0,0,0,0);
    add(1,9,0, 0,0,0,0);
    add(1,9,0, 1,9,1,1);
    add(1,9,0, 1,9,1,1);
    add(0,0,0, 1,9,1,1);
    add(0,0,0, 1,9,1,1);
    add(0,0,0, 1,9,1,0);
    add(0,0,1, 0,0,0,0);
    // release bounce on key 7
    add(1,7,0, 0,0,0,0);
    add(1,7,0, 0,0,0,0);
    for (int k = 0; k < 4; k++) add(1,7,0, 1,7,1,1);
    add(0,0,0, 1,7,1,1);
    add(0,0,0, 1,7,1,1);
    add(1,7,0, 1,7,1,1);
    add(1,7,0, 1,7,1,1);
    add(0,0,0, 1,7,1,1);
    add(0,0,0, 1,7,1,1);
    for (int k = 0; k < 3; k++) add(0,0,0, 1,7,1,0);
    add(0,0,1, 0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      kif.valid    = tbl[i].v;
      kif.code     = tbl[i].c;
      kif.ev_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d ev_valid", i), 8'(kif.ev_valid), 8'(tbl[i].exp_ev));
      chk($sformatf("vec%0d ev_code", i),  8'(kif.ev_code),  8'(tbl[i].exp_code));
      chk($sformatf("vec%0d count", i),    8'(kif.count),    8'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d pressed", i),  8'(kif.pressed),  8'(tbl[i].exp_pr));
      chk($sformatf("vec%0d overflow", i), 8'(kif.overflow), 8'd0);
    end
    kif.ev_ready = 1'b0;

    // overflow: five presses into a depth-4 queue
    for (int k = 1; k <= 5; k++) press(4'(k));
    chk("ovf count",    8'(kif.count),    8'd4);
    chk("ovf flag",     8'(kif.overflow), 8'd1);
    chk("ovf head",     8'(kif.ev_code),  8'd1);
    kif.ev_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d code", k), 8'(kif.ev_code), 8'(k));
      chk($sformatf("drain%0d valid", k), 8'(kif.ev_valid), 8'd1);
      step();
    end
    kif.ev_ready = 1'b0;
    chk("drained valid", 8'(kif.ev_valid), 8'd0);
    chk("drained count", 8'(kif.count),    8'd0);
    chk("ovf sticky",    8'(kif.overflow), 8'd1);
    kif.clr_ovf = 1'b1;
    step();
    kif.clr_ovf = 1'b0;
    chk("ovf cleared",   8'(kif.overflow), 8'd0);

    // full queue: qualifying press coincides with a pop
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    chk("full count", 8'(kif.count), 8'd4);
    kif.valid = 1'b1;
    kif.code  = 4'hE;
    step();
    step();
    kif.ev_ready = 1'b1;
    step();
    kif.ev_ready = 1'b0;
    chk("pp count",    8'(kif.count),    8'd4);
    chk("pp overflow", 8'(kif.overflow), 8'd0);
    chk("pp head",     8'(kif.ev_code),  8'hB);
    chk("pp pressed",  8'(kif.pressed),  8'd1);
    kif.valid = 1'b0;
    kif.code  = 4'd0;
    repeat (3) step();
    chk("pp released", 8'(kif.pressed), 8'd0);
    exp_q = '{4'hB, 4'hC, 4'hD, 4'hE};
    kif.ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp drain%0d", k), 8'(kif.ev_code), 8'(exp_q[k]));
      step();
    end
    kif.ev_ready = 1'b0;
    chk("pp empty", 8'(kif.ev_valid), 8'd0);

    // asynchronous reset while HELD with two events queued
    press(4'h6);
    kif.valid = 1'b1;
    kif.code  = 4'h8;
    repeat (3) step();
    chk("pre-rst count",   8'(kif.count),   8'd2);
    chk("pre-rst pressed", 8'(kif.pressed), 8'd1);
    chk("pre-rst head",    8'(kif.ev_code), 8'h6);
    #2;
    reset = 1'b0;
    #1;
    chk("arst ev_valid", 8'(kif.ev_valid), 8'd0);
    chk("arst ev_code",  8'(kif.ev_code),  8'd0);
    chk("arst count",    8'(kif.count),    8'd0);
    chk("arst pressed",  8'(kif.pressed),  8'd0);
    chk("arst overflow", 8'(kif.overflow), 8'd0);
    step();
    reset = 1'b1;
    step();
    step();
    chk("requal early count",   8'(kif.count),   8'd0);
    chk("requal early pressed", 8'(kif.pressed), 8'd0);
    step();
    chk("requal count",   8'(kif.count),    8'd1);
    chk("requal code",    8'(kif.ev_code),  8'h8);
    chk("requal pressed", 8'(kif.pressed),  8'd1);
    kif.valid = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
